// File: rtl/fabosc_pkg.sv
// Shared widths, helper functions and the per-channel divider state type for
// the fabric clock-enable generator.
package fabosc_pkg;

    localparam int DIV_W_DEF = 16;
    // Upper bound on DIV_W; the divider state is stored zero-extended to this.
    localparam int DIV_W_MAX = 32;

    typedef logic [DIV_W_MAX-1:0] div_max_t;

    typedef struct packed {
        div_max_t active;
        div_max_t pending;
        logic     pend_vld;
    } div_state_t;

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Wide enough to hold XTL_WIN-1 for the window counter; also used for the edge counter.
    function automatic int mon_cnt_w(input int win);
        return (win <= 2) ? 1 : $clog2(win);
    endfunction

endpackage

// File: rtl/fabosc_div_ch.sv
// One clock-enable channel: programmable modulo counter, pending divider
// register applied at terminal count, and the registered enable strobe.
module fabosc_div_ch
    import fabosc_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             clken_o
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

    div_state_t       st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clken_q, clken_d;
    div_max_t         wr_div_ext;
    logic             running;
    logic             term;

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        clken_d    = 1'b0;
        wr_div_ext = div_max_t'(wr_div_i);
        running    = (st_q.active != '0);
        term       = running && (div_max_t'(cnt_q) == st_q.active - div_max_t'(1));

        // SYNC and an idle channel share one path: a write (or a leftover
        // pending value) takes effect at once and the phase restarts at 0.
        if (sync_i || !running) begin
            if (wr_i) begin
                st_d.active = wr_div_ext;
            end else if (st_q.pend_vld) begin
                st_d.active = st_q.pending;
            end
            st_d.pend_vld = 1'b0;
            cnt_d         = '0;
        end else begin
            clken_d = term;
            if (term) begin
                cnt_d = '0;
                if (st_q.pend_vld) begin
                    st_d.active   = st_q.pending;
                    st_d.pend_vld = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            // A write landing on the terminal cycle queues behind the value applied now.
            if (wr_i) begin
                st_d.pending  = wr_div_ext;
                st_d.pend_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= '{active: div_max_t'(RST_DIV), pending: '0, pend_vld: 1'b0};
            cnt_q   <= '0;
            clken_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            clken_q <= clken_d;
        end
    end

    assign clken_o = clken_q;

endmodule

// File: rtl/fabosc_clken_gen.sv
// Multi-channel clock-enable generator on the RC-oscillator fabric clock.
// Define FABOSC_XTL_MON_EN to build the crystal-oscillator frequency monitor.
module fabosc_clken_gen
    import fabosc_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DIV_W     = DIV_W_DEF,
    parameter int  RESET_DIV = 0,
    parameter int  XTL_WIN   = 50000,
    parameter int  XTL_MIN   = 180,
    parameter int  XTL_MAX   = 220,
    localparam int CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              SYNC,
    input  logic              WR_EN,
    input  logic [CH_W-1:0]   WR_CH,
    input  logic [DIV_W-1:0]  WR_DIV,
    output logic              WR_ERR,
    output logic [NUM_CH-1:0] CLKEN,
    input  logic              XTL,
    output logic              XTL_OK
);

    localparam int CH_SPAN = 1 << CH_W;

    logic [NUM_CH-1:0] wr_sel;
    logic              wr_ch_bad;
    logic              wr_err_q, wr_err_d;
    logic              xtl_ok_q, xtl_ok_d;

    // Out-of-range indices only exist when NUM_CH is not a power of two.
    if (CH_SPAN > NUM_CH) begin : g_err_chk
        assign wr_ch_bad = (int'(WR_CH) >= NUM_CH);
    end else begin : g_err_none
        assign wr_ch_bad = 1'b0;
    end

    assign wr_err_d = WR_EN & wr_ch_bad;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr_sel[gi] = WR_EN && (int'(WR_CH) == gi);

        fabosc_div_ch #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk_i    (CLK),
            .rst_ni   (RESETN),
            .sync_i   (SYNC),
            .wr_i     (wr_sel[gi]),
            .wr_div_i (WR_DIV),
            .clken_o  (CLKEN[gi])
        );
    end

`ifdef FABOSC_XTL_MON_EN
    localparam int MON_W = mon_cnt_w(XTL_WIN);

    logic             xtl_meta_q, xtl_sync_q, xtl_prev_q;
    logic             xtl_rise;
    logic             win_end;
    logic [MON_W-1:0] win_cnt_q, win_cnt_d;
    logic [MON_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [MON_W-1:0] edge_sum;

    always_comb begin
        xtl_rise   = xtl_sync_q & ~xtl_prev_q;
        win_end    = (win_cnt_q == MON_W'(XTL_WIN - 1));
        // The edge seen on the window's last cycle still belongs to that window.
        edge_sum   = (xtl_rise && (edge_cnt_q != '1)) ? edge_cnt_q + MON_W'(1) : edge_cnt_q;
        win_cnt_d  = win_end ? '0 : win_cnt_q + MON_W'(1);
        edge_cnt_d = win_end ? '0 : edge_sum;
        xtl_ok_d   = xtl_ok_q;
        if (win_end) begin
            xtl_ok_d = (int'(edge_sum) >= XTL_MIN) && (int'(edge_sum) <= XTL_MAX);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            xtl_meta_q <= 1'b0;
            xtl_sync_q <= 1'b0;
            xtl_prev_q <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            xtl_ok_q   <= 1'b0;
        end else begin
            xtl_meta_q <= XTL;
            xtl_sync_q <= xtl_meta_q;
            xtl_prev_q <= xtl_sync_q;
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            xtl_ok_q   <= xtl_ok_d;
        end
    end
`else
    logic          unused_xtl;
    localparam int unused_xtl_cfg = XTL_WIN + XTL_MIN + XTL_MAX;

    assign unused_xtl = XTL;
    assign xtl_ok_d   = 1'b1;

    // Monitor absent: report OK from the first clock after reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            xtl_ok_q <= 1'b0;
        end else begin
            xtl_ok_q <= xtl_ok_d;
        end
    end
`endif

    assign WR_ERR = wr_err_q;
    assign XTL_OK = xtl_ok_q;

endmodule
